// File: rtl/gate_arb_pkg.sv
// Shared definitions for the gate arbiter: op codes, FSM state encoding, default width.
package gate_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gate_arb_gates.sv
// 1-bit gates unit: every gate is evaluated and the op code muxes one onto y.
module gate_arb_gates
  import gate_arb_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  logic [7:0] gate_w;

  always_comb begin
    gate_w          = '0;
    gate_w[OP_AND]  = a & b;
    gate_w[OP_OR]   = a | b;
    gate_w[OP_NOT]  = ~a;
    gate_w[OP_XOR]  = a ^ b;
    gate_w[OP_NAND] = ~(a & b);
    gate_w[OP_NOR]  = ~(a | b);
    gate_w[OP_XNOR] = ~(a ^ b);
    gate_w[OP_RSVD] = 1'b0;
    y               = gate_w[op];
  end

endmodule

// File: rtl/gate_arbiter.sv
// Two-requester bit-serial logic unit. Optional reserved-op flag port res_err
// is built when GATE_ARB_ERR_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// a requester holds valid and payload until ready, the producer holds res_* until res_ready.
module gate_arbiter
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in0_b,
  input  logic [2:0]       in0_op,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in1_b,
  input  logic [2:0]       in1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef GATE_ARB_ERR_EN
  output logic             res_err,
`endif
  output state_t           dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_data_q, res_data_d;
  logic [2:0]       op_q, op_d;
  logic             id_q, id_d, last_q, last_d;
  logic             res_valid_q, res_valid_d, res_id_q, res_id_d;
  logic             any_valid, grant_id, accept, gate_y;

  // Both valid -> the requester not granted last time wins.
  always_comb begin
    any_valid = in0_valid | in1_valid;
    grant_id  = (in0_valid && in1_valid) ? ~last_q : in1_valid;
    accept    = (state_q == ST_IDLE) && any_valid && !rst;
    in0_ready = accept && !grant_id;
    in1_ready = accept && grant_id;
  end

  gate_arb_gates u_gates (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .op (op_q),
    .y  (gate_y)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    last_d      = last_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = grant_id ? in1_a  : in0_a;
          b_d     = grant_id ? in1_b  : in0_b;
          op_d    = grant_id ? in1_op : in0_op;
          id_d    = grant_id;
          last_d  = grant_id;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d[cnt_q] = gate_y;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // First DONE cycle publishes the result; outputs then hold until handoff.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_q;
          res_id_d    = id_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

`ifdef GATE_ARB_ERR_EN
  logic res_err_q, res_err_d;

  always_comb begin
    res_err_d = res_err_q;
    if (state_q == ST_DONE && !res_valid_q) res_err_d = (op_q == OP_RSVD);
  end

  always_ff @(posedge clk) begin
    if (rst) res_err_q <= 1'b0;
    else     res_err_q <= res_err_d;
  end

  assign res_err = res_err_q;
`endif

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign dbg_state = state_q;

endmodule
